// File: rtl/ccd_phase_sequencer.sv
// CCD line readout sequencer: per pixel emits phi_r, settle gap, phi_p and gap
// with programmable widths, and drives the phase-mux select line.
//
// state  | meaning
// IDLE   | waiting for start, phases low, selector on phi_r
// RST    | phi_r high
// SETTLE | gap after phi_r, selector still on phi_r
// SIG    | phi_p high, selector on phi_p
// GAP    | gap after phi_p, then next pixel or DONE
// DONE   | one-cycle completion pulse
module ccd_phase_sequencer #(
  parameter int CNT_W = 8,
  parameter int PIX_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PIX_W-1:0] i_num_pix,
  input  logic [CNT_W-1:0] i_t_rst,
  input  logic [CNT_W-1:0] i_t_settle,
  input  logic [CNT_W-1:0] i_t_sig,
  input  logic [CNT_W-1:0] i_t_gap,
  output logic             o_phi_r,
  output logic             o_phi_p,
  output logic             o_selector,
  output logic             o_busy,
  output logic             o_done,
  output logic [PIX_W-1:0] o_pix_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SETTLE, S_SIG, S_GAP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0] num_pix_q;
  logic [CNT_W-1:0] t_rst_q, t_settle_q, t_sig_q, t_gap_q;
  logic             load_cfg;
  logic             last_pix;

  // A zero duration behaves as one cycle, so the down-counter reload is max(t,1)-1.
  function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  assign last_pix = (pix_cnt_q == num_pix_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    pix_cnt_d = pix_cnt_q;
    load_cfg  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          load_cfg  = 1'b1;
          pix_cnt_d = '0;
          ph_cnt_d  = reload(i_t_rst);
          state_d   = (i_num_pix == '0) ? S_DONE : S_RST;
        end
      end
      S_RST: begin
        if (ph_cnt_q == '0) begin
          state_d  = S_SETTLE;
          ph_cnt_d = reload(t_settle_q);
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (ph_cnt_q == '0) begin
          state_d  = S_SIG;
          ph_cnt_d = reload(t_sig_q);
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      S_SIG: begin
        if (ph_cnt_q == '0) begin
          state_d  = S_GAP;
          ph_cnt_d = reload(t_gap_q);
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (ph_cnt_q == '0) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RST;
            pix_cnt_d = pix_cnt_q + 1'b1;
            ph_cnt_d  = reload(t_rst_q);
          end
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ph_cnt_q   <= '0;
      pix_cnt_q  <= '0;
      num_pix_q  <= '0;
      t_rst_q    <= '0;
      t_settle_q <= '0;
      t_sig_q    <= '0;
      t_gap_q    <= '0;
    end else begin
      state_q   <= state_d;
      ph_cnt_q  <= ph_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      if (load_cfg) begin
        num_pix_q  <= i_num_pix;
        t_rst_q    <= i_t_rst;
        t_settle_q <= i_t_settle;
        t_sig_q    <= i_t_sig;
        t_gap_q    <= i_t_gap;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_phi_r    <= 1'b0;
      o_phi_p    <= 1'b0;
      o_selector <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_phi_r    <= (state_d == S_RST);
      o_phi_p    <= (state_d == S_SIG);
      o_selector <= !((state_d == S_SIG) || (state_d == S_GAP));
      o_busy     <= (state_d == S_RST) || (state_d == S_SETTLE) ||
                    (state_d == S_SIG) || (state_d == S_GAP);
      o_done     <= (state_d == S_DONE);
    end
  end

  assign o_pix_cnt = pix_cnt_q;

endmodule

// File: tb/tb_ccd_phase_sequencer.sv
// Bench for ccd_phase_sequencer: table-driven lines, random lines against a
// per-cycle waveform model, and a reset-during-SIG sequence.
module tb_ccd_phase_sequencer;
  localparam int CNT_W = 8;
  localparam int PIX_W = 12;
  localparam int VW    = 5 + PIX_W;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic [PIX_W-1:0] i_num_pix = '0;
  logic [CNT_W-1:0] i_t_rst = '0, i_t_settle = '0, i_t_sig = '0, i_t_gap = '0;
  logic             o_phi_r, o_phi_p, o_selector, o_busy, o_done;
  logic [PIX_W-1:0] o_pix_cnt;

  ccd_phase_sequencer #(.CNT_W(CNT_W), .PIX_W(PIX_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_pix(i_num_pix),
    .i_t_rst(i_t_rst), .i_t_settle(i_t_settle), .i_t_sig(i_t_sig), .i_t_gap(i_t_gap),
    .o_phi_r(o_phi_r), .o_phi_p(o_phi_p), .o_selector(o_selector),
    .o_busy(o_busy), .o_done(o_done), .o_pix_cnt(o_pix_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int num_pix;
    int t_rst, t_settle, t_sig, t_gap;
    bit disturb;
    int exp_done_lat;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [VW-1:0] outs();
    return {o_phi_r, o_phi_p, o_selector, o_busy, o_done, o_pix_cnt};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] exp);
    logic [VW-1:0] act;
    act = outs();
    tests++;
    if (act !== exp || (o_phi_r && o_phi_p)) begin
      fails++;
      $display("FAIL %s: got r=%b p=%b sel=%b busy=%b done=%b pix=%0d, want r=%b p=%b sel=%b busy=%b done=%b pix=%0d",
               name, act[VW-1], act[VW-2], act[VW-3], act[VW-4], act[VW-5], act[PIX_W-1:0],
               exp[VW-1], exp[VW-2], exp[VW-3], exp[VW-4], exp[VW-5], exp[PIX_W-1:0]);
    end
  endtask

  function automatic int max1(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  // Expected output stream from the cycle after start through the DONE cycle.
  task automatic build_model(input vec_t v, output logic [VW-1:0] q[$]);
    logic [PIX_W-1:0] p;
    logic [PIX_W-1:0] last;
    q = {};
    for (int pix = 0; pix < v.num_pix; pix++) begin
      p = PIX_W'(pix);
      repeat (max1(v.t_rst))    q.push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, p});
      repeat (max1(v.t_settle)) q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, p});
      repeat (max1(v.t_sig))    q.push_back({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, p});
      repeat (max1(v.t_gap))    q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, p});
    end
    last = (v.num_pix == 0) ? '0 : PIX_W'(v.num_pix - 1);
    q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, last});
  endtask

  task automatic run_line(input string name, input vec_t v, output int lat);
    logic [VW-1:0] q[$];
    logic [PIX_W-1:0] last;
    build_model(v, q);
    i_num_pix  = PIX_W'(v.num_pix);
    i_t_rst    = CNT_W'(v.t_rst);
    i_t_settle = CNT_W'(v.t_settle);
    i_t_sig    = CNT_W'(v.t_sig);
    i_t_gap    = CNT_W'(v.t_gap);
    i_start    = 1'b1;
    step();
    i_start = 1'b0;
    lat = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (v.disturb) begin
        i_start    = 1'($urandom);
        i_num_pix  = PIX_W'($urandom);
        i_t_rst    = CNT_W'($urandom);
        i_t_settle = CNT_W'($urandom);
        i_t_sig    = CNT_W'($urandom);
        i_t_gap    = CNT_W'($urandom);
      end
      check($sformatf("%s cyc%0d", name, i + 1), q[i]);
      if (o_done && lat < 0) lat = i + 1;
      step();
    end
    i_start = 1'b0;
    last = (v.num_pix == 0) ? '0 : PIX_W'(v.num_pix - 1);
    check({name, " idle"}, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, last});
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int lat;

    tbl[0] = '{1, 2, 1, 3, 1, 0, 8};
    tbl[1] = '{3, 1, 1, 1, 1, 0, 13};
    tbl[2] = '{0, 5, 5, 5, 5, 0, 1};
    tbl[3] = '{2, 0, 0, 0, 0, 0, 9};
    tbl[4] = '{1, 255, 0, 0, 0, 0, 259};
    tbl[5] = '{4, 1, 2, 1, 2, 1, 25};

    step();
    step();
    i_rst = 1'b0;
    check("reset", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {PIX_W{1'b0}}});
    step();
    check("idle", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {PIX_W{1'b0}}});

    for (int k = 0; k < 6; k++) begin
      run_line($sformatf("tbl%0d", k), tbl[k], lat);
      tests++;
      if (lat != tbl[k].exp_done_lat) begin
        fails++;
        $display("FAIL tbl%0d done latency: got %0d, want %0d", k, lat, tbl[k].exp_done_lat);
      end
      step();
    end

    for (int k = 0; k < 25; k++) begin
      v.num_pix  = $urandom_range(0, 4);
      v.t_rst    = $urandom_range(0, 6);
      v.t_settle = $urandom_range(0, 6);
      v.t_sig    = $urandom_range(0, 6);
      v.t_gap    = $urandom_range(0, 6);
      v.disturb  = 1'($urandom);
      v.exp_done_lat = 0;
      run_line($sformatf("rnd%0d", k), v, lat);
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset asserted while phi_p is high.
    v = '{1, 2, 1, 3, 1, 0, 8};
    i_num_pix = 12'd1; i_t_rst = 8'd2; i_t_settle = 8'd1; i_t_sig = 8'd3; i_t_gap = 8'd1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(); step(); step();
    check("pre-reset sig", {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {PIX_W{1'b0}}});
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("reset in sig", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {PIX_W{1'b0}}});
    step();
    check("post-reset idle", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {PIX_W{1'b0}}});
    run_line("after reset", v, lat);
    tests++;
    if (lat != 8) begin
      fails++;
      $display("FAIL after reset done latency: got %0d, want 8", lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
